// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and defaults for the register-file writeback controller.
package regfile_wb_arbiter_pkg;

  localparam int DEF_XLEN = 64;
  localparam int DEF_NREG = 32;
  localparam int DEF_AW   = 5;

  // Writeback source encoding, also the encoding of the arbiter's last_grant state.
  typedef enum logic {
    WB_SRC_EXU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/regfile_wb_arbiter_arb2.sv
// Two-way round-robin arbiter. req[0]=EXU, req[1]=LSU; gnt is one-hot or zero.
// On a tie the requester that did not win last time is granted.
module wb_rr_arb2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  wb_src_e last_grant_q, last_grant_d;

  // Grant selection and last-winner tracking; a grant is always a transfer.
  always_comb begin
    gnt          = 2'b00;
    last_grant_d = last_grant_q;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant_q == WB_SRC_LSU) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    if (gnt[0])      last_grant_d = WB_SRC_EXU;
    else if (gnt[1]) last_grant_d = WB_SRC_LSU;
  end

  // LSU is the reset winner so EXU takes the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= WB_SRC_LSU;
    else     last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback controller: shares the register file write port between EXU and LSU,
// and tracks pending writes per register for decode hazard stalls.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NREG = DEF_NREG,
  parameter int AW   = DEF_AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            issue_ready,
  input  logic            exu_valid,
  input  logic [AW-1:0]   exu_rd,
  input  logic [XLEN-1:0] exu_data,
  output logic            exu_ready,
  input  logic            lsu_valid,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [NREG-1:0] busy,
  output logic            sb_err
);

  logic [1:0]      gnt;
  logic            wb_fire;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [NREG-1:0] set_vec, clr_vec;

  logic            rf_we_q,    rf_we_d;
  logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0] busy_q,     busy_d;
  logic            sb_err_q,   sb_err_d;

  wb_rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({lsu_valid, exu_valid}),
    .gnt (gnt)
  );

  assign exu_ready = gnt[0];
  assign lsu_ready = gnt[1];

  // Payload mux, scoreboard update and next write-port values.
  always_comb begin
    wb_fire     = |gnt;
    wb_rd       = gnt[0] ? exu_rd   : lsu_rd;
    wb_data     = gnt[0] ? exu_data : lsu_data;
    // Readers see the registered scoreboard only; a bit clearing this cycle still stalls.
    issue_ready = (issue_rd == '0) || !busy_q[issue_rd];

    set_vec = '0;
    clr_vec = '0;
    if (issue_valid && issue_ready && (issue_rd != '0)) set_vec[issue_rd] = 1'b1;
    if (wb_fire && (wb_rd != '0))                       clr_vec[wb_rd]    = 1'b1;
    // Clear applies to the old state, then the new issue is added, so a stray
    // clear can never wipe out a freshly issued pending write.
    busy_d = (busy_q & ~clr_vec) | set_vec;

    sb_err_d   = wb_fire && (wb_rd != '0) && !busy_q[wb_rd];
    rf_we_d    = wb_fire && (wb_rd != '0);
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (rf_we_d) begin
      rf_waddr_d = wb_rd;
      rf_wdata_d = wb_data;
    end
  end

  // Write-port register and scoreboard state; reset drops any in-flight write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
      sb_err_q   <= 1'b0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
      sb_err_q   <= sb_err_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = busy_q;
  assign sb_err   = sb_err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, reset-in-flight sequence,
// then constrained-random traffic against a behavioural scoreboard model.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue_valid = 1'b0, issue_ready;
  logic [4:0]  issue_rd = '0;
  logic        exu_valid = 1'b0, exu_ready;
  logic [4:0]  exu_rd = '0;
  logic [63:0] exu_data = '0;
  logic        lsu_valid = 1'b0, lsu_ready;
  logic [4:0]  lsu_rd = '0;
  logic [63:0] lsu_data = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [31:0] busy;
  logic        sb_err;

  int n_chk  = 0;
  int n_fail = 0;

  regfile_wb_arbiter dut (
    .clk (clk), .rst (rst),
    .issue_valid (issue_valid), .issue_rd (issue_rd), .issue_ready (issue_ready),
    .exu_valid (exu_valid), .exu_rd (exu_rd), .exu_data (exu_data), .exu_ready (exu_ready),
    .lsu_valid (lsu_valid), .lsu_rd (lsu_rd), .lsu_data (lsu_data), .lsu_ready (lsu_ready),
    .rf_we (rf_we), .rf_waddr (rf_waddr), .rf_wdata (rf_wdata),
    .busy (busy), .sb_err (sb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [4:0] ird,
                       input logic ev, input logic [4:0] erd, input logic [63:0] ed,
                       input logic lv, input logic [4:0] lrd, input logic [63:0] ld);
    issue_valid = iv; issue_rd = ird;
    exu_valid = ev; exu_rd = erd; exu_data = ed;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
  endtask

  // One row = one cycle: inputs applied after the edge, outputs seen mid-cycle.
  typedef struct {
    logic iv; logic [4:0] ird;
    logic ev; logic [4:0] erd; logic [63:0] ed;
    logic lv; logic [4:0] lrd; logic [63:0] ld;
    logic x_ir; logic x_er; logic x_lr; logic x_we;
    logic [4:0] x_wa; logic [63:0] x_wd; logic [31:0] x_busy; logic x_sb;
  } vec_t;

  vec_t tbl [12];

  // Behavioural model state for the random phase.
  bit          mb [32];
  bit          m_last_exu;
  bit          m_we, m_sb;
  logic [4:0]  m_addr;
  logic [63:0] m_data;

  function automatic logic [31:0] model_busy();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = mb[i];
    return v;
  endfunction

  function automatic logic [4:0] pick_rd();
    if ($urandom_range(0, 7) == 0) return 5'd0;
    if ($urandom_range(0, 3) != 0)
      for (int t = 0; t < 8; t++) begin
        logic [4:0] r = 5'($urandom_range(1, 31));
        if (mb[r]) return r;
      end
    return 5'($urandom_range(1, 31));
  endfunction

  initial begin
    tbl[0]  = '{1'b1,5'd5, 1'b0,5'd0,64'h0,    1'b0,5'd0,64'h0,    1'b1,1'b0,1'b0,1'b0,5'd0,64'h0,    32'h00,1'b0};
    tbl[1]  = '{1'b1,5'd5, 1'b1,5'd5,64'h1234, 1'b0,5'd0,64'h0,    1'b0,1'b1,1'b0,1'b0,5'd0,64'h0,    32'h20,1'b0};
    tbl[2]  = '{1'b1,5'd3, 1'b0,5'd0,64'h0,    1'b0,5'd0,64'h0,    1'b1,1'b0,1'b0,1'b1,5'd5,64'h1234, 32'h00,1'b0};
    tbl[3]  = '{1'b1,5'd4, 1'b0,5'd0,64'h0,    1'b0,5'd0,64'h0,    1'b1,1'b0,1'b0,1'b0,5'd0,64'h0,    32'h08,1'b0};
    tbl[4]  = '{1'b0,5'd0, 1'b1,5'd3,64'hA1,   1'b1,5'd4,64'hB1,   1'b1,1'b0,1'b1,1'b0,5'd0,64'h0,    32'h18,1'b0};
    tbl[5]  = '{1'b1,5'd4, 1'b1,5'd3,64'hA1,   1'b1,5'd4,64'hB2,   1'b1,1'b1,1'b0,1'b1,5'd4,64'hB1,   32'h08,1'b0};
    tbl[6]  = '{1'b1,5'd3, 1'b1,5'd3,64'hA2,   1'b1,5'd4,64'hB2,   1'b1,1'b0,1'b1,1'b1,5'd3,64'hA1,   32'h10,1'b0};
    tbl[7]  = '{1'b0,5'd0, 1'b1,5'd3,64'hA2,   1'b0,5'd0,64'h0,    1'b1,1'b1,1'b0,1'b1,5'd4,64'hB2,   32'h08,1'b0};
    tbl[8]  = '{1'b0,5'd0, 1'b0,5'd0,64'h0,    1'b1,5'd0,64'hFFFF, 1'b1,1'b0,1'b1,1'b1,5'd3,64'hA2,   32'h00,1'b0};
    tbl[9]  = '{1'b0,5'd0, 1'b1,5'd7,64'h77,   1'b0,5'd0,64'h0,    1'b1,1'b1,1'b0,1'b0,5'd0,64'h0,    32'h00,1'b0};
    tbl[10] = '{1'b0,5'd0, 1'b0,5'd0,64'h0,    1'b0,5'd0,64'h0,    1'b1,1'b0,1'b0,1'b1,5'd7,64'h77,   32'h00,1'b1};
    tbl[11] = '{1'b0,5'd0, 1'b0,5'd0,64'h0,    1'b0,5'd0,64'h0,    1'b1,1'b0,1'b0,1'b0,5'd0,64'h0,    32'h00,1'b0};

    // Reset values
    #1 rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("reset rf_we", 64'(rf_we), 64'h0);
    chk("reset rf_waddr", 64'(rf_waddr), 64'h0);
    chk("reset rf_wdata", rf_wdata, 64'h0);
    chk("reset busy", 64'(busy), 64'h0);
    chk("reset sb_err", 64'(sb_err), 64'h0);
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      drive(tbl[i].iv, tbl[i].ird, tbl[i].ev, tbl[i].erd, tbl[i].ed, tbl[i].lv, tbl[i].lrd, tbl[i].ld);
      @(negedge clk);
      chk($sformatf("row%0d issue_ready", i), 64'(issue_ready), 64'(tbl[i].x_ir));
      chk($sformatf("row%0d exu_ready", i), 64'(exu_ready), 64'(tbl[i].x_er));
      chk($sformatf("row%0d lsu_ready", i), 64'(lsu_ready), 64'(tbl[i].x_lr));
      chk($sformatf("row%0d rf_we", i), 64'(rf_we), 64'(tbl[i].x_we));
      chk($sformatf("row%0d busy", i), 64'(busy), 64'(tbl[i].x_busy));
      chk($sformatf("row%0d sb_err", i), 64'(sb_err), 64'(tbl[i].x_sb));
      if (tbl[i].x_we) begin
        chk($sformatf("row%0d rf_waddr", i), 64'(rf_waddr), 64'(tbl[i].x_wa));
        chk($sformatf("row%0d rf_wdata", i), rf_wdata, tbl[i].x_wd);
      end
    end

    // Reset asserted with busy=0x180 and an EXU grant about to be written
    @(posedge clk); #1 drive(1'b1, 5'd7, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
    @(posedge clk); #1 drive(1'b1, 5'd8, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
    @(posedge clk); #1 drive(1'b0, 5'd0, 1'b1, 5'd7, 64'h55, 1'b0, 5'd0, 64'h0);
    @(negedge clk);
    chk("rst6 busy before", 64'(busy), 64'h180);
    chk("rst6 exu_ready before", 64'(exu_ready), 64'h1);
    rst = 1'b1;
    #1;
    chk("rst6 busy async", 64'(busy), 64'h0);
    chk("rst6 rf_we async", 64'(rf_we), 64'h0);
    @(posedge clk); #1;
    chk("rst6 write dropped", 64'(rf_we), 64'h0);
    rst = 1'b0;
    drive(1'b0, 5'd0, 1'b1, 5'd1, 64'h1, 1'b1, 5'd2, 64'h2);
    @(negedge clk);
    chk("rst6 tie exu_ready", 64'(exu_ready), 64'h1);
    chk("rst6 tie lsu_ready", 64'(lsu_ready), 64'h0);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);

    // Random traffic against the model
    @(negedge clk); rst = 1'b1; #1 rst = 1'b0;
    for (int i = 0; i < 32; i++) mb[i] = 1'b0;
    m_last_exu = 1'b0; m_we = 1'b0; m_sb = 1'b0; m_addr = '0; m_data = '0;
    begin
      bit e_v = 0, l_v = 0, e_took = 0, l_took = 0;
      logic [4:0] e_rd = '0, l_rd = '0, i_rd;
      logic [63:0] e_d = '0, l_d = '0;
      bit i_v, x_ir, x_er, x_lr;
      logic [4:0] w_rd;
      logic [63:0] w_d;
      for (int cyc = 0; cyc < 2000; cyc++) begin
        @(posedge clk); #1;
        if (!e_v || e_took) begin
          e_v = bit'($urandom_range(0, 1)); e_rd = pick_rd(); e_d = {$urandom, $urandom};
        end
        if (!l_v || l_took) begin
          l_v = bit'($urandom_range(0, 1)); l_rd = pick_rd(); l_d = {$urandom, $urandom};
        end
        i_v  = ($urandom_range(0, 2) != 0);
        i_rd = 5'($urandom_range(0, 31));
        drive(i_v, i_rd, e_v, e_rd, e_d, l_v, l_rd, l_d);
        @(negedge clk);
        x_ir = (i_rd == 0) || !mb[i_rd];
        if (e_v && l_v) x_er = !m_last_exu; else x_er = e_v;
        x_lr = l_v && !x_er;
        chk("rand issue_ready", 64'(issue_ready), 64'(x_ir));
        chk("rand exu_ready", 64'(exu_ready), 64'(x_er));
        chk("rand lsu_ready", 64'(lsu_ready), 64'(x_lr));
        chk("rand rf_we", 64'(rf_we), 64'(m_we));
        chk("rand busy", 64'(busy), 64'(model_busy()));
        chk("rand sb_err", 64'(sb_err), 64'(m_sb));
        if (m_we) begin
          chk("rand rf_waddr", 64'(rf_waddr), 64'(m_addr));
          chk("rand rf_wdata", rf_wdata, m_data);
        end
        // Advance the model to the next edge
        m_we = 1'b0; m_sb = 1'b0;
        if (x_er || x_lr) begin
          w_rd = x_er ? e_rd : l_rd;
          w_d  = x_er ? e_d  : l_d;
          m_last_exu = x_er;
          if (w_rd != 0) begin
            m_sb = !mb[w_rd];
            mb[w_rd] = 1'b0;
            m_we = 1'b1; m_addr = w_rd; m_data = w_d;
          end
        end
        if (i_v && x_ir && i_rd != 0) mb[i_rd] = 1'b1;
        e_took = x_er; l_took = x_lr;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
